// File: rtl/layer_output_serializer.sv
// layer_output_serializer
//   Collects one activation per neuron of a hidden layer (each neuron pulses its own
//   valid bit, in any order) into a capture bank. Once every slot is filled, the bank
//   is handed to a send bank and streamed out one word per cycle toward the next layer.
//   The next frame is collected while the current one is being sent.
//
// Ports
//   clk           clock, rising edge
//   rst           synchronous, active-high reset
//   neuron_valid  bit k = valid pulse of neuron k
//   neuron_data   neuron k activation in bits [k*IN_WIDTH +: IN_WIDTH]
//   out_data      serialized word (activation zero-extended to DATA_WIDTH)
//   out_valid     word valid
//   out_last      high with the word of neuron NUM_NEURONS-1
//   busy          a frame is being sent
//   err_overflow  sticky: a neuron delivered a second activation into a filled slot
//   frame_count   number of frames fully sent (wraps)
//
// FSM states
//   state | meaning
//   IDLE  | nothing to send, waiting for a full capture bank
//   SEND  | streaming send bank word idx
module layer_output_serializer #(
    parameter int NUM_NEURONS = 30,
    parameter int IN_WIDTH    = 16,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_NEURONS-1:0]          neuron_valid,
    input  logic [NUM_NEURONS*IN_WIDTH-1:0] neuron_data,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_valid,
    output logic                            out_last,
    output logic                            busy,
    output logic                            err_overflow,
    output logic [15:0]                     frame_count
);

    localparam int IDX_W = $clog2(NUM_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt;
    logic [IN_WIDTH-1:0]    cap_bank  [NUM_NEURONS];
    logic [IN_WIDTH-1:0]    send_bank [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] flag;
    logic [NUM_NEURONS-1:0] cap_en;
    logic                   all_full;
    logic                   frame_done;
    logic                   xfer;
    logic                   overflow_hit;
    logic [IN_WIDTH-1:0]    word_nxt;

    assign all_full   = &flag;
    assign frame_done = (state == SEND) && (idx == LAST_IDX);
    assign xfer       = all_full && ((state == IDLE) || frame_done);

    // On a transfer edge the bank is emptied, so every pulsing neuron lands in the
    // fresh bank and none of them counts as an overflow.
    assign cap_en       = neuron_valid & (~flag | {NUM_NEURONS{xfer}});
    assign overflow_hit = (|(neuron_valid & flag)) && !xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (xfer) begin
                    state_nxt = SEND;
                    idx_nxt   = '0;
                end
            end
            SEND: begin
                if (frame_done) begin
                    idx_nxt = '0;
                    if (!xfer) state_nxt = IDLE;
                end else begin
                    idx_nxt = idx + IDX_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
        // The send bank is only loaded at this same edge on a transfer, so word 0 of
        // the new frame has to come straight from the capture bank.
        word_nxt = xfer ? cap_bank[0] : send_bank[idx_nxt];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag         <= '0;
            err_overflow <= 1'b0;
            frame_count  <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            flag <= xfer ? cap_en : (flag | cap_en);
            if (overflow_hit) err_overflow <= 1'b1;
            if (frame_done) frame_count <= frame_count + 16'd1;
            out_valid <= (state_nxt == SEND);
            busy      <= (state_nxt == SEND);
            out_last  <= (state_nxt == SEND) && (idx_nxt == LAST_IDX);
            if (state_nxt == SEND) out_data <= DATA_WIDTH'(word_nxt);
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_NEURONS; k++) begin
            if (cap_en[k]) cap_bank[k] <= neuron_data[k*IN_WIDTH +: IN_WIDTH];
            if (xfer) send_bank[k] <= cap_bank[k];
        end
    end

endmodule

// File: tb/tb_layer_output_serializer.sv
module tb_layer_output_serializer;

    localparam int N  = 4;
    localparam int IW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  neuron_valid = '0;
    logic [N*IW-1:0] neuron_data = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          busy;
    logic          err_overflow;
    logic [15:0]   frame_count;

    layer_output_serializer #(
        .NUM_NEURONS(N),
        .IN_WIDTH   (IW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .neuron_valid(neuron_valid),
        .neuron_data (neuron_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .busy        (busy),
        .err_overflow(err_overflow),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h", nm, act, exp);
    endtask

    // Reference model: capture slots with fill flags, and a queue holding the words
    // still to be shown on the output (front = word currently on the output).
    bit [IW-1:0] m_slot [N];
    bit [N-1:0]  m_flag;
    bit [IW-1:0] outq[$];
    bit [15:0]   m_fc;
    bit          m_ovf;
    bit [IW-1:0] m_data;
    bit          m_init = 1'b0;
    bit          m_full;

    always @(posedge clk) begin
        if (rst) begin
            outq.delete();
            m_flag = '0;
            m_fc   = '0;
            m_ovf  = 1'b0;
            m_data = '0;
            m_init = 1'b1;
        end else begin
            m_full = (m_flag == {N{1'b1}});
            if (outq.size() > 0) begin
                if (outq.size() == 1) m_fc = m_fc + 16'd1;
                void'(outq.pop_front());
            end
            if (m_full && outq.size() == 0) begin
                for (int k = 0; k < N; k++) outq.push_back(m_slot[k]);
                m_flag = '0;
            end
            for (int k = 0; k < N; k++) begin
                if (neuron_valid[k]) begin
                    if (m_flag[k]) m_ovf = 1'b1;
                    else begin
                        m_slot[k] = neuron_data[k*IW +: IW];
                        m_flag[k] = 1'b1;
                    end
                end
            end
            if (outq.size() > 0) m_data = outq[0];
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("model_out_valid", {31'b0, out_valid}, {31'b0, outq.size() > 0});
            chk("model_out_last",  {31'b0, out_last},  {31'b0, outq.size() == 1});
            chk("model_busy",      {31'b0, busy},      {31'b0, outq.size() > 0});
            chk("model_out_data",  {16'b0, out_data},  {24'b0, m_data});
            chk("model_err_overflow", {31'b0, err_overflow}, {31'b0, m_ovf});
            chk("model_frame_count", {16'b0, frame_count}, {16'b0, m_fc});
        end
    end

    task automatic step(input logic [N-1:0] v, input logic [N*IW-1:0] d);
        neuron_valid = v;
        neuron_data  = d;
        @(posedge clk);
        #1;
        neuron_valid = '0;
    endtask

    logic [9:0] vmask, lmask;

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_out_valid", {31'b0, out_valid}, 0);
        chk("reset_busy", {31'b0, busy}, 0);
        chk("reset_out_data", {16'b0, out_data}, 0);
        chk("reset_frame_count", {16'b0, frame_count}, 0);
        chk("reset_err", {31'b0, err_overflow}, 0);

        // single-cycle full frame
        step(4'hF, 32'h44332211);
        chk("t1_no_word_yet", {31'b0, out_valid}, 0);
        step('0, '0);
        chk("t1_w0_valid", {31'b0, out_valid}, 1);
        chk("t1_w0", {16'b0, out_data}, 32'h0011);
        step('0, '0);
        chk("t1_w1", {16'b0, out_data}, 32'h0022);
        step('0, '0);
        chk("t1_w2", {16'b0, out_data}, 32'h0033);
        step('0, '0);
        chk("t1_w3", {16'b0, out_data}, 32'h0044);
        chk("t1_last", {31'b0, out_last}, 1);
        step('0, '0);
        chk("t1_done_valid", {31'b0, out_valid}, 0);
        chk("t1_done_busy", {31'b0, busy}, 0);
        chk("t1_frame_count", {16'b0, frame_count}, 1);

        // staggered arrival k=2,0,3,1
        step(4'b0100, 32'hD4C3B2A1);
        step(4'b0001, 32'hD4C3B2A1);
        step(4'b1000, 32'hD4C3B2A1);
        chk("t2_partial_idle", {31'b0, out_valid}, 0);
        step(4'b0010, 32'hD4C3B2A1);
        chk("t2_after_last_pulse", {31'b0, out_valid}, 0);
        step('0, '0);
        chk("t2_w0", {16'b0, out_data}, 32'h00A1);
        step('0, '0);
        chk("t2_w1", {16'b0, out_data}, 32'h00B2);
        step('0, '0);
        chk("t2_w2", {16'b0, out_data}, 32'h00C3);
        step('0, '0);
        chk("t2_w3", {16'b0, out_data}, 32'h00D4);
        step('0, '0);
        chk("t2_frame_count", {16'b0, frame_count}, 2);

        // back-to-back frames
        step(4'hF, 32'h04030201);
        vmask = '0;
        lmask = '0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) step(4'hF, 32'h08070605);
            else step('0, '0);
            vmask[i] = out_valid;
            lmask[i] = out_last;
            if (i == 4) chk("t3_f2_w0", {16'b0, out_data}, 32'h0005);
        end
        chk("t3_valid_run", {22'b0, vmask}, 32'h0FF);
        chk("t3_last_pulses", {22'b0, lmask}, 32'h088);
        chk("t3_frame_count", {16'b0, frame_count}, 4);

        // neuron 0 pulses on the transfer edge
        step(4'hF, 32'h14131211);
        step(4'b0001, 32'h00000099);
        chk("t5_w0", {16'b0, out_data}, 32'h0011);
        chk("t5_no_overflow", {31'b0, err_overflow}, 0);
        repeat (3) step('0, '0);
        step(4'b1110, 32'h9C9B9A00);
        step('0, '0);
        chk("t5_new_w0", {16'b0, out_data}, 32'h0099);
        repeat (4) step('0, '0);
        chk("t5_err_still_0", {31'b0, err_overflow}, 0);
        chk("t5_frame_count", {16'b0, frame_count}, 6);

        // duplicate pulse from neuron 1
        step(4'b0010, 32'h00005500);
        step(4'b0010, 32'h00006600);
        chk("t4_overflow", {31'b0, err_overflow}, 1);
        step(4'b1101, 32'h44330011);
        step('0, '0);
        chk("t4_w0", {16'b0, out_data}, 32'h0011);
        step('0, '0);
        chk("t4_w1_first_kept", {16'b0, out_data}, 32'h0055);
        repeat (3) step('0, '0);
        chk("t4_overflow_sticky", {31'b0, err_overflow}, 1);
        chk("t4_frame_count", {16'b0, frame_count}, 7);

        // reset in the middle of a frame with a partial next bank
        step(4'hF, 32'h2B2A2928);
        step(4'b0011, 32'h0000C1C0);
        step('0, '0);
        step('0, '0);
        chk("t6_w2_before_rst", {16'b0, out_data}, 32'h002A);
        rst = 1'b1;
        step('0, '0);
        rst = 1'b0;
        chk("t6_rst_valid", {31'b0, out_valid}, 0);
        chk("t6_rst_frame_count", {16'b0, frame_count}, 0);
        chk("t6_rst_err", {31'b0, err_overflow}, 0);
        step(4'b1100, 32'hE4E30000);
        step('0, '0);
        chk("t6_flags_cleared", {31'b0, out_valid}, 0);
        step(4'b0011, 32'h0000E2E1);
        step('0, '0);
        chk("t6_new_w0", {16'b0, out_data}, 32'h00E1);
        repeat (4) step('0, '0);
        chk("t6_frame_count", {16'b0, frame_count}, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
